// File: rtl/adventure_text_pkg.sv
// adventure_text_pkg: character/row types, blank cell value, room name table and sword status strings
package adventure_text_pkg;
    typedef logic [7:0] char_t;
    typedef char_t [15:0] row_t;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam char_t SPACE = 8'h20;
    localparam row_t ROOM_NAMES [8] = '{
        "CAVE ENTRANCE   ",
        "TWISTY TUNNEL   ",
        "RAPID RIVER     ",
        "SWORD ROOM      ",
        "DRAGON DEN      ",
        "VICTORY         ",
        "GRAVEYARD       ",
        "UNKNOWN         "
    };
    localparam row_t SWORD_YES = "SWORD: YES      ";
    localparam row_t SWORD_NO  = "SWORD: NO       ";
endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle strobe every DIV enabled cycles, with synchronous clear
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    // strobe on the last count of each period and wrap; clear overrides counting
    always_comb begin
        tick  = en && cnt_q == W'(DIV - 1);
        cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/room_text_writer.sv
// room_text_writer: rewrites the 2x16 LCD text buffer one cell per cycle whenever room or sword changes; ROOM_TEXT_SCROLL_EN adds row-0 scrolling while idle
module room_text_writer
    import adventure_text_pkg::*;
#(
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic [2:0]            rooms,
    input  logic                  sword,
    output logic [1:0][15:0][7:0] characters,
    output logic                  busy,
    output logic                  frame_done
);
    state_t                state_q, state_d;
    logic [2:0]            room_q, room_d;
    logic                  sword_q, sword_d;
    logic                  dirty_q, dirty_d;
    logic [4:0]            idx_q, idx_d;
    logic [1:0][15:0][7:0] cells_q, cells_d;
    row_t                  text;
    // next state, snapshot capture on leaving IDLE, and one cell write per FILL cycle
    always_comb begin
        state_d = state_q;
        room_d  = room_q;
        sword_d = sword_q;
        dirty_d = dirty_q;
        idx_d   = idx_q;
        cells_d = cells_q;
        text    = idx_q[4] ? (sword_q ? SWORD_YES : SWORD_NO) : ROOM_NAMES[room_q];
        case (state_q)
            IDLE: if (dirty_q || {rooms, sword} != {room_q, sword_q}) begin
                state_d = FILL;
                room_d  = rooms;
                sword_d = sword;
                dirty_d = 1'b0;
                idx_d   = '0;
            end
            FILL: begin
                cells_d[idx_q[4]][idx_q[3:0]] = text[~idx_q[3:0]];
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy       = state_q != IDLE;
        frame_done = state_q == DONE;
    end
    // state, snapshot and buffer registers; reset blanks the buffer and forces a first frame
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= IDLE;
            room_q  <= '0;
            sword_q <= 1'b0;
            dirty_q <= 1'b1;
            idx_q   <= '0;
            cells_q <= {32{SPACE}};
        end else begin
            state_q <= state_d;
            room_q  <= room_d;
            sword_q <= sword_d;
            dirty_q <= dirty_d;
            idx_q   <= idx_d;
            cells_q <= cells_d;
        end
    end
`ifdef ROOM_TEXT_SCROLL_EN
    logic       start, tick;
    logic [3:0] off_q, off_d;
    assign start = state_q == IDLE && state_d == FILL;
    tick_divider #(.DIV(SCROLL_DIV)) u_div (
        .clk (CLOCK_50),
        .rst (Reset),
        .clr (start),
        .en  (state_q == IDLE),
        .tick(tick)
    );
    // scroll offset advances on divider strobes in IDLE and restarts with each new frame
    always_comb begin
        off_d = start ? 4'd0 : tick ? off_q + 4'd1 : off_q;
    end
    // offset register
    always_ff @(posedge CLOCK_50) begin
        if (Reset) off_q <= '0;
        else off_q <= off_d;
    end
    // row 0 is presented rotated left by the offset; row 1 is passed through
    always_comb begin
        characters[1] = cells_q[1];
        for (int c = 0; c < 16; c++) characters[0][c] = cells_q[0][4'(c) + off_q];
    end
`else
    assign characters = cells_q;
`endif
endmodule

// File: tb/tb_room_text_writer.sv
// tb_room_text_writer: scoreboard bench; stimulus queues expected frames, a monitor checks each frame_done
module tb_room_text_writer;
    typedef logic [1:0][15:0][7:0] frame_t;
    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [2:0]            rooms = 3'd0;
    logic                  sword = 1'b0;
    frame_t                characters;
    logic                  busy, frame_done;
    int                    checks = 0;
    int                    failures = 0;
    frame_t                exp_q[$];

    always #5 clk = ~clk;

`ifdef ROOM_TEXT_SCROLL_EN
    room_text_writer #(.SCROLL_DIV(4)) dut (
`else
    room_text_writer dut (
`endif
        .CLOCK_50  (clk),
        .Reset     (rst),
        .rooms     (rooms),
        .sword     (sword),
        .characters(characters),
        .busy      (busy),
        .frame_done(frame_done)
    );

    function automatic frame_t mk(input logic [127:0] r0, input logic [127:0] r1);
        frame_t f;
        for (int c = 0; c < 16; c++) begin
            f[0][c] = r0[127 - 8*c -: 8];
            f[1][c] = r1[127 - 8*c -: 8];
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // nb: busy cycles before the pulse, nc: negedges until the pulse, b1: busy at the first negedge
    task automatic wait_frame(output int nb, output int nc, output logic b1);
        nb = 0;
        nc = 0;
        b1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            nc++;
            if (nc == 1) b1 = busy;
            if (frame_done === 1'b1) return;
            if (busy === 1'b1) nb++;
        end
        checks++;
        failures++;
        $display("FAIL frame_timeout actual=no_frame_done required=frame_done_within_200");
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0");
            end else begin
                chk("frame_text", characters, exp_q.pop_front());
            end
        end
    end

    initial begin
        int   nb, nc, bad;
        logic b1;
        frame_t snap;
        // reset held for two cycles
        @(negedge clk);
        chk("reset_cells", characters, {32{8'h20}});
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        @(negedge clk);
        exp_q.push_back(mk("CAVE ENTRANCE   ", "SWORD: NO       "));
        rst = 1'b0;
        wait_frame(nb, nc, b1);
        chk("rel_busy_edge1", b1, 1);
        chk("rel_done_cycle", nc, 33);
        chk("rel_fill_len", nb, 32);
        // room change from idle
        @(negedge clk);
        exp_q.push_back(mk("SWORD ROOM      ", "SWORD: NO       "));
        rooms = 3'd3;
        wait_frame(nb, nc, b1);
        chk("room_fill_len", nb, 32);
        chk("room_done_cycle", nc, 33);
        @(negedge clk);
        chk("done_one_cycle", frame_done, 0);
        chk("idle_after_done", busy, 0);
        // sword flips mid-frame at index 10
        exp_q.push_back(mk("TWISTY TUNNEL   ", "SWORD: NO       "));
        exp_q.push_back(mk("TWISTY TUNNEL   ", "SWORD: YES      "));
        rooms = 3'd1;
        repeat (11) @(negedge clk);
        sword = 1'b1;
        wait_frame(nb, nc, b1);
        chk("mid_first_rest", nb, 21);
        wait_frame(nb, nc, b1);
        chk("mid_idle_gap", b1, 0);
        chk("mid_second_len", nb, 32);
        chk("mid_second_done", nc, 34);
        // reset at index 20 aborts the frame
        @(negedge clk);
        rooms = 3'd2;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cells", characters, {32{8'h20}});
        chk("abort_busy", busy, 0);
        chk("abort_done", frame_done, 0);
        exp_q.push_back(mk("RAPID RIVER     ", "SWORD: YES      "));
        rst = 1'b0;
        wait_frame(nb, nc, b1);
        chk("abort_refill_len", nb, 32);
        chk("abort_refill_done", nc, 33);
`ifdef ROOM_TEXT_SCROLL_EN
        @(negedge clk);
        exp_q.push_back(mk("VICTORY         ", "SWORD: YES      "));
        rooms = 3'd5;
        wait_frame(nb, nc, b1);
        repeat (5) @(negedge clk);
        chk("scroll_step1", characters[0][0], "I");
        repeat (4) @(negedge clk);
        chk("scroll_step2", characters[0][0], "C");
        chk("scroll_row1", characters[1][0], "S");
        exp_q.push_back(mk("CAVE ENTRANCE   ", "SWORD: YES      "));
        rooms = 3'd0;
        wait_frame(nb, nc, b1);
        chk("scroll_reset_len", nb, 32);
`else
        @(negedge clk);
        snap = characters;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (characters !== snap || busy !== 1'b0) bad++;
        end
        chk("idle_static", bad, 0);
        chk("idle_text", characters, mk("RAPID RIVER     ", "SWORD: YES      "));
`endif
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/room_text_writer.md
ROOM_TEXT_WRITER -- requirements
Module: room_text_writer

Interface
REQ-001 Parameter SCROLL_DIV, default 25_000_000, CLOCK_50 cycles per row-0 scroll step (used only with ROOM_TEXT_SCROLL_EN).
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 rooms  input  3  current room code from the room FSM.
REQ-005 sword  input  1  sword-held flag.
REQ-006 characters  output  2x16x8  display buffer, [row][col] ASCII, consumed by the LCD driver.
REQ-007 busy  output  1  high while a frame rewrite is in progress.
REQ-008 frame_done  output  1  one-cycle pulse when a rewrite completes.

Function
REQ-009 The FSM SHALL have the states IDLE, FILL and DONE.
REQ-010 The block SHALL register rooms and sword into snapshot registers when it leaves IDLE; FILL text comes only from the snapshot.
REQ-011 The IDLE->FILL transition SHALL occur when the live {rooms,sword} differs from the snapshot or the dirty flag is set; the dirty flag SHALL be cleared on entry to FILL.
REQ-012 FILL SHALL write exactly one cell per cycle, index 0..31: row 0 cols 0..15, then row 1 cols 0..15; the FILL->DONE transition SHALL occur after index 31.
REQ-013 Row 0 SHALL be the room name for the snapshot room, left-aligned and space-padded (0x20) to 16 characters.
REQ-014 Row 1 SHALL be "SWORD: YES" if the snapshot sword is 1, else "SWORD: NO", space-padded to 16 characters.
REQ-015 Room names SHALL be: 0 "CAVE ENTRANCE", 1 "TWISTY TUNNEL", 2 "RAPID RIVER", 3 "SWORD ROOM", 4 "DRAGON DEN", 5 "VICTORY", 6 "GRAVEYARD", 7 "UNKNOWN".
REQ-016 busy SHALL be high in FILL and DONE and low in IDLE.
REQ-017 DONE SHALL last one cycle, assert frame_done for that cycle, then return to IDLE.
REQ-018 Latency SHALL be as follows: an input change sampled in IDLE at edge N gives busy=1 after N, the last cell written at N+32, and frame_done high for the cycle after N+32.
REQ-019 Input changes during FILL/DONE SHALL NOT alter the frame in progress; they SHALL be detected on the first IDLE cycle by the snapshot compare, causing an immediate new FILL.
REQ-020 Unwritten cells SHALL hold their previous value during FILL, so a partial frame is visible for at most 32 cycles.

Reset
REQ-021 Reset SHALL set all 32 cells to 0x20, state to IDLE, busy=0, frame_done=0, snapshot to 0, scroll offset and divider to 0, and dirty=1.
REQ-022 Reset SHALL take priority over every other action, including mid-FILL.
REQ-023 After Reset deasserts, the block SHALL start a full FILL on the first IDLE cycle even if the inputs equal the snapshot.

Configuration
REQ-024 Macro ROOM_TEXT_SCROLL_EN defined: in IDLE, row 0 as presented SHALL rotate left by one cell every SCROLL_DIV cycles (col 0 wraps to col 15), offset modulo 16.
REQ-025 With the macro defined, entry to FILL SHALL reset the scroll offset and divider to 0, and they SHALL be held during FILL/DONE; row 1 never scrolls.
REQ-026 Macro undefined: there SHALL be no divider or offset logic and row 0 SHALL be static; SCROLL_DIV SHALL be ignored.

Structure
REQ-027 Package adventure_text_pkg SHALL hold the char_t (8-bit) and row_t (16 x char_t) typedefs, the SPACE constant (0x20), the 8-entry room name table and the two sword strings.
REQ-028 One sub-module, tick_divider (SCROLL_DIV cycle strobe with synchronous clear), SHALL be instantiated only under ROOM_TEXT_SCROLL_EN.

Verification
REQ-029 Reset for 2 cycles, release with rooms=0, sword=0 -> all cells 0x20 during reset; busy at edge 1; frame_done at cycle 33; row0 "CAVE ENTRANCE   ", row1 "SWORD: NO       ".
REQ-030 From idle, rooms 0->3 -> exactly 32 busy cycles, one frame_done pulse, row0 "SWORD ROOM      ", row1 unchanged.
REQ-031 sword 0->1 at FILL index 10 -> the current frame completes with "NO"; a second FILL starts on the next IDLE cycle; row1 ends "SWORD: YES      ".
REQ-032 Reset asserted at FILL index 20 -> next cycle all cells 0x20, busy=0, no frame_done; a full FILL follows on release.
REQ-033 ROOM_TEXT_SCROLL_EN, SCROLL_DIV=4, rooms=5 idle -> row0 col0 = 'I' after 4 cycles, 'C' after 8 cycles; an input change restores offset 0.
REQ-034 Macro undefined, 1000 idle cycles -> characters constant, busy=0.
